// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one DecoupledGcd engine
// between NUM_REQ requesters. Each accepted request's requester index is
// queued in a tag FIFO, so results, which come back in acceptance order,
// can be steered to the requester that issued them.
// Optional feature macro: GCD_ARB_STATS_EN adds saturating 16-bit
// per-requester acceptance counters on grant_count. Without it,
// grant_count is tied to zero.
module gcd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 60,
    parameter int TAG_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_bits_value1,
    input  logic [NUM_REQ*WIDTH-1:0] req_bits_value2,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_bits_value1,
    output logic [WIDTH-1:0]         resp_bits_value2,
    output logic [WIDTH-1:0]         resp_bits_gcd,
    output logic                     gcd_input_valid,
    input  logic                     gcd_input_ready,
    output logic [WIDTH-1:0]         gcd_input_bits_value1,
    output logic [WIDTH-1:0]         gcd_input_bits_value2,
    input  logic                     gcd_output_valid,
    output logic                     gcd_output_ready,
    input  logic [WIDTH-1:0]         gcd_output_bits_value1,
    input  logic [WIDTH-1:0]         gcd_output_bits_value2,
    input  logic [WIDTH-1:0]         gcd_output_bits_gcd,
    output logic                     err_orphan,
    output logic [NUM_REQ*16-1:0]    grant_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_q;

    logic [IDX_W-1:0] tags_q [TAG_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_orphan_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic [IDX_W-1:0] head;
    logic             push;
    logic             pop;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign head       = tags_q[rd_ptr_q];
    assign push       = (state_q == OFFER) && gcd_input_ready;
    assign pop        = gcd_output_valid && gcd_output_ready;

    assign gcd_input_valid  = (state_q == OFFER);
    assign err_orphan       = err_orphan_q;
    assign resp_bits_value1 = gcd_output_bits_value1;
    assign resp_bits_value2 = gcd_output_bits_value2;
    assign resp_bits_gcd    = gcd_output_bits_gcd;

    // Round-robin pick: walk from last+NUM_REQ down to last+1 so the
    // nearest valid requester after `last` is the one that sticks.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Offer mux and per-requester ready/valid steering (request by grant,
    // response by FIFO head).
    always_comb begin
        gcd_input_bits_value1 = '0;
        gcd_input_bits_value2 = '0;
        req_ready             = '0;
        resp_valid            = '0;
        gcd_output_ready      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                gcd_input_bits_value1 = req_bits_value1[i*WIDTH +: WIDTH];
                gcd_input_bits_value2 = req_bits_value2[i*WIDTH +: WIDTH];
                req_ready[i]          = (state_q == OFFER) && gcd_input_ready;
            end
            if (head == IDX_W'(i)) begin
                resp_valid[i]    = gcd_output_valid && !fifo_empty;
                gcd_output_ready = resp_ready[i] && !fifo_empty;
            end
        end
    end

    // Arbiter FSM: IDLE picks a requester when there is tag space, OFFER
    // holds the grant until the engine takes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found && !fifo_full) begin
                        grant_q <= sel_idx;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (gcd_input_ready) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag FIFO control state; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clock) begin
        if (push) begin
            tags_q[wr_ptr_q] <= grant_q;
        end
    end

    // Sticky flag for an engine result arriving with no outstanding tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_orphan_q <= 1'b0;
        end else if (gcd_output_valid && fifo_empty) begin
            err_orphan_q <= 1'b1;
        end
    end

`ifdef GCD_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Saturating per-requester acceptance counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: a buffered engine stand-in plus directed requests;
// a monitor pushes expected results on acceptance and checks them on return.
module tb_gcd_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 60;
    localparam int TAG_DEPTH = 4;
    localparam int MAXP      = 16;

    logic                     clock;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_bits_value1;
    logic [NUM_REQ*WIDTH-1:0] req_bits_value2;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_bits_value1;
    logic [WIDTH-1:0]         resp_bits_value2;
    logic [WIDTH-1:0]         resp_bits_gcd;
    logic                     gcd_input_valid;
    logic                     gcd_input_ready;
    logic [WIDTH-1:0]         gcd_input_bits_value1;
    logic [WIDTH-1:0]         gcd_input_bits_value2;
    logic                     gcd_output_valid;
    logic                     gcd_output_ready;
    logic [WIDTH-1:0]         gcd_output_bits_value1;
    logic [WIDTH-1:0]         gcd_output_bits_value2;
    logic [WIDTH-1:0]         gcd_output_bits_gcd;
    logic                     err_orphan;
    logic [NUM_REQ*16-1:0]    grant_count;

    gcd_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bits_value1(req_bits_value1), .req_bits_value2(req_bits_value2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bits_value1(resp_bits_value1), .resp_bits_value2(resp_bits_value2),
        .resp_bits_gcd(resp_bits_gcd),
        .gcd_input_valid(gcd_input_valid), .gcd_input_ready(gcd_input_ready),
        .gcd_input_bits_value1(gcd_input_bits_value1),
        .gcd_input_bits_value2(gcd_input_bits_value2),
        .gcd_output_valid(gcd_output_valid), .gcd_output_ready(gcd_output_ready),
        .gcd_output_bits_value1(gcd_output_bits_value1),
        .gcd_output_bits_value2(gcd_output_bits_value2),
        .gcd_output_bits_gcd(gcd_output_bits_gcd),
        .err_orphan(err_orphan), .grant_count(grant_count)
    );

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] v1;
        logic [WIDTH-1:0] v2;
        logic [WIDTH-1:0] g;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] v1;
        logic [WIDTH-1:0] v2;
    } eng_t;

    // Pending requests per requester, with hand-computed expected gcd.
    logic [WIDTH-1:0] p_v1 [NUM_REQ][MAXP];
    logic [WIDTH-1:0] p_v2 [NUM_REQ][MAXP];
    logic [WIDTH-1:0] p_g  [NUM_REQ][MAXP];
    int               p_wr [NUM_REQ];
    int               p_rd [NUM_REQ];

    exp_t sb[$];
    eng_t eng_q[$];
    int   ord_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_total = 0;
    int acc_cyc [NUM_REQ];

    bit                 in_rdy_en;
    bit                 force_ov;
    logic [NUM_REQ-1:0] rr_en;

    initial clock = 1'b0;
    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Drive every DUT input from the bench state.
    task automatic update_inputs();
        eng_t h;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p_rd[i] != p_wr[i]) begin
                req_valid[i] = 1'b1;
                req_bits_value1[i*WIDTH +: WIDTH] = p_v1[i][p_rd[i] % MAXP];
                req_bits_value2[i*WIDTH +: WIDTH] = p_v2[i][p_rd[i] % MAXP];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        gcd_input_ready = in_rdy_en;
        resp_ready      = rr_en;
        if (eng_q.size() > 0) begin
            h = eng_q[0];
            gcd_output_valid       = 1'b1;
            gcd_output_bits_value1 = h.v1;
            gcd_output_bits_value2 = h.v2;
            gcd_output_bits_gcd    = gcd_f(h.v1, h.v2);
        end else begin
            gcd_output_valid       = force_ov;
            gcd_output_bits_value1 = '0;
            gcd_output_bits_value2 = '0;
            gcd_output_bits_gcd    = '0;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        update_inputs();
        #1;
    endtask

    task automatic add_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] g);
        p_v1[i][p_wr[i] % MAXP] = a;
        p_v2[i][p_wr[i] % MAXP] = b;
        p_g[i][p_wr[i] % MAXP]  = g;
        p_wr[i]++;
        update_inputs();
    endtask

    function automatic bit idle_now();
        bit r;
        r = (sb.size() == 0) && (eng_q.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p_rd[i] != p_wr[i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_acc(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (acc_total < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(acc_total >= target), 64'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = idle_now();
        while (!done && n < budget) begin
            tick();
            n++;
            done = idle_now();
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Monitor: samples 1 ns before each rising edge, tracks engine and
    // request handshakes, and scores every response handshake.
    initial begin
        exp_t e;
        eng_t t;
        int   hits;
        int   o;
        forever begin
            @(negedge clock);
            #4;
            cyc++;
            if (gcd_output_valid && gcd_output_ready && eng_q.size() > 0) begin
                void'(eng_q.pop_front());
            end
            if (gcd_input_valid && gcd_input_ready) begin
                t.v1 = gcd_input_bits_value1;
                t.v2 = gcd_input_bits_value2;
                eng_q.push_back(t);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cyc[i] = cyc;
                    acc_total++;
                    e.idx = i;
                    e.v1  = p_v1[i][p_rd[i] % MAXP];
                    e.v2  = p_v2[i][p_rd[i] % MAXP];
                    e.g   = p_g[i][p_rd[i] % MAXP];
                    sb.push_back(e);
                    p_rd[i]++;
                    if (ord_q.size() > 0) begin
                        o = ord_q.pop_front();
                        check("accept_order", 64'(i), 64'(o));
                    end
                end
            end
            hits = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (resp_valid[i]) hits++;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    check("resp_onehot", 64'(hits), 64'd1);
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 64'(i), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        check("resp_idx", 64'(i), 64'(e.idx));
                        check("resp_value1", 64'(resp_bits_value1), 64'(e.v1));
                        check("resp_value2", 64'(resp_bits_value2), 64'(e.v2));
                        check("resp_gcd", 64'(resp_bits_gcd), 64'(e.g));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        int gexp [NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) begin
            p_wr[i] = 0;
            p_rd[i] = 0;
            acc_cyc[i] = 0;
        end
        req_valid = '0;
        req_bits_value1 = '0;
        req_bits_value2 = '0;
        gcd_input_ready = 1'b0;
        resp_ready = '0;
        gcd_output_valid = 1'b0;
        gcd_output_bits_value1 = '0;
        gcd_output_bits_value2 = '0;
        gcd_output_bits_gcd = '0;
        in_rdy_en = 1'b1;
        force_ov = 1'b0;
        rr_en = '1;
        reset_n = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_in_valid", 64'(gcd_input_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_out_ready", 64'(gcd_output_ready), 64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);
        check("rst_grant_count", 64'(grant_count), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single requester: accepted one cycle after first offer edge
        c0 = cyc;
        add_req(0, 12, 18, 6);
        wait_acc("single_acc", 1, 20);
        check("single_latency", 64'(acc_cyc[0] - c0), 64'd2);
        wait_idle("single_drain", 30);

        // Round robin from a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        ord_q = '{0, 1, 2, 3, 0};
        base = acc_total;
        add_req(0, 2, 4, 2);
        add_req(0, 2, 4, 2);
        add_req(1, 3, 6, 3);
        add_req(2, 4, 8, 4);
        add_req(3, 5, 10, 5);
        wait_acc("rr_acc", base + 5, 60);
        wait_idle("rr_drain", 60);
        check("rr_order_left", 64'(ord_q.size()), 64'd0);
`ifdef GCD_ARB_STATS_EN
        gexp = '{2, 1, 1, 1};
`else
        gexp = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            check("grant_count", 64'(grant_count[i*16 +: 16]), 64'(gexp[i]));
        end

        // FIFO full: four outstanding, fifth waits for a pop
        rr_en = '0;
        base = acc_total;
        add_req(1, 8, 12, 4);
        add_req(2, 9, 6, 3);
        add_req(3, 10, 15, 5);
        add_req(0, 14, 21, 7);
        add_req(0, 27, 18, 9);
        wait_acc("full_acc4", base + 4, 40);
        repeat (10) tick();
        check("full_hold_acc", 64'(acc_total - base), 64'd4);
        check("full_no_offer", 64'(gcd_input_valid), 64'd0);
        check("full_resp_valid", 64'(resp_valid), 64'b0010);
        check("full_out_ready", 64'(gcd_output_ready), 64'd0);
        rr_en = '1;
        update_inputs();
        wait_acc("full_acc5", base + 5, 40);
        wait_idle("full_drain", 80);

        // Backpressure on the engine input during OFFER
        in_rdy_en = 1'b0;
        add_req(2, 48, 36, 12);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(gcd_input_valid), 64'd1);
            check("bp_value1", 64'(gcd_input_bits_value1), 64'd48);
            check("bp_value2", 64'(gcd_input_bits_value2), 64'd36);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        in_rdy_en = 1'b1;
        update_inputs();
        c0 = cyc;
        tick();
        check("bp_accept_cycle", 64'(acc_cyc[2] - c0), 64'd1);
        wait_idle("bp_drain", 40);

        // Reset with two requests outstanding
        rr_en = '0;
        base = acc_total;
        add_req(1, 20, 30, 10);
        add_req(3, 6, 9, 3);
        wait_acc("mr_acc", base + 2, 30);
        tick();
        check("mr_pre_resp_valid", 64'(resp_valid), 64'b1000);
        #1 reset_n = 1'b0;
        #1;
        check("mr_in_valid", 64'(gcd_input_valid), 64'd0);
        check("mr_req_ready", 64'(req_ready), 64'd0);
        check("mr_resp_valid", 64'(resp_valid), 64'd0);
        check("mr_out_ready", 64'(gcd_output_ready), 64'd0);
        check("mr_grant_count", 64'(grant_count), 64'd0);
        sb.delete();
        eng_q.delete();
        for (int i = 0; i < NUM_REQ; i++) p_rd[i] = p_wr[i];
        rr_en = '1;
        tick();
        reset_n = 1'b1;
        tick();

        // Orphan result with an empty FIFO
        force_ov = 1'b1;
        update_inputs();
        #1;
        check("orphan_out_ready", 64'(gcd_output_ready), 64'd0);
        check("orphan_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        check("orphan_set", 64'(err_orphan), 64'd1);
        force_ov = 1'b0;
        update_inputs();
        repeat (3) tick();
        check("orphan_sticky", 64'(err_orphan), 64'd1);

        // Normal operation after reset
        base = acc_total;
        add_req(0, 35, 21, 7);
        wait_acc("post_rst_acc", base + 1, 20);
        wait_idle("post_rst_drain", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
